// File: rtl/booth_op_sequencer_pkg.sv
// booth_pkg: shared widths, defaults and sequencer state encoding for the Booth front end
package booth_pkg;
  localparam int DEF_WIDTH_IN = 16;
  localparam int DEF_WIDTH_FP = 32;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TIMEOUT = 24;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} seq_state_e;
endpackage

// File: rtl/booth_op_sequencer_if.sv
// booth_op_sequencer_if: request, multiplier and result handshakes of the operand sequencer
interface booth_op_sequencer_if #(
  parameter int WIDTH_IN = booth_pkg::DEF_WIDTH_IN,
  parameter int WIDTH_FP = booth_pkg::DEF_WIDTH_FP,
  parameter int TAG_W = booth_pkg::DEF_TAG_W,
  parameter int DEPTH = booth_pkg::DEF_DEPTH
);
  logic in_valid, in_ready;
  logic [WIDTH_IN-1:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH_IN-1:0] mul_a, mul_b;
  logic mul_valid_in, mul_valid_out;
  logic [WIDTH_FP-1:0] mul_product;
  logic out_valid, out_ready, out_timeout;
  logic [WIDTH_FP-1:0] out_product;
  logic [TAG_W-1:0] out_tag;
  logic busy;
  logic [$clog2(DEPTH):0] fifo_count;
  modport slave (
    input in_valid, in_a, in_b, in_tag, mul_valid_out, mul_product, out_ready,
    output in_ready, mul_a, mul_b, mul_valid_in, out_valid, out_product, out_tag, out_timeout, busy, fifo_count
  );
  modport master (
    output in_valid, in_a, in_b, in_tag, mul_valid_out, mul_product, out_ready,
    input in_ready, mul_a, mul_b, mul_valid_in, out_valid, out_product, out_tag, out_timeout, busy, fifo_count
  );
endinterface

// File: rtl/booth_op_sequencer_fifo.sv
// operand_fifo: DEPTH-entry synchronous FIFO of packed {tag, a, b} with occupancy count
module operand_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: queues multiply requests and runs them one at a time through the Booth datapath,
// returning tagged products or a timeout marker on the result port.
module booth_op_sequencer #(
  parameter int WIDTH_IN = booth_pkg::DEF_WIDTH_IN,
  parameter int WIDTH_FP = booth_pkg::DEF_WIDTH_FP,
  parameter int TAG_W = booth_pkg::DEF_TAG_W,
  parameter int DEPTH = booth_pkg::DEF_DEPTH,
  parameter int TIMEOUT = booth_pkg::DEF_TIMEOUT
) (
  input logic clk,
  input logic reset,
  booth_op_sequencer_if.slave bus
);
  import booth_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = TAG_W + 2 * WIDTH_IN;
  seq_state_e state_q, state_d;
  logic [TW-1:0] wait_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic [FW-1:0] head;
  logic [AW:0] count;
  logic can_issue, timed_out, issue, finish;
  assign bus.in_ready = !count[AW] && !reset;
  assign bus.fifo_count = count;
  assign bus.busy = state_q != IDLE || count != '0;
  operand_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(bus.in_valid && bus.in_ready),
    .pop(issue),
    .din({bus.in_tag, bus.in_a, bus.in_b}),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  // issue only when the result slot is free, so a new result never overwrites an unread one
  always_comb begin
    can_issue = count != '0 && (!bus.out_valid || bus.out_ready);
    timed_out = wait_cnt == TW'(TIMEOUT - 1);
    state_d = state_q == IDLE ? (can_issue ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              (bus.mul_valid_out || timed_out) ? IDLE : WAIT;
  end
  always_comb begin
    issue = state_q == IDLE && state_d == ISSUE;
    finish = state_q == WAIT && state_d == IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      bus.mul_valid_in <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_product <= '0;
      bus.out_tag <= '0;
      bus.out_timeout <= 1'b0;
      cur_tag <= '0;
      wait_cnt <= '0;
    end else begin
      bus.mul_valid_in <= issue;
      wait_cnt <= issue ? '0 : state_q != IDLE ? wait_cnt + TW'(1) : wait_cnt;
      if (issue) {cur_tag, bus.mul_a, bus.mul_b} <= head;
      if (finish) begin
        bus.out_valid <= 1'b1;
        bus.out_product <= bus.mul_valid_out ? bus.mul_product : '0;
        bus.out_tag <= cur_tag;
        bus.out_timeout <= !bus.mul_valid_out;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_booth_op_sequencer.sv
// tb_booth_op_sequencer: directed scenarios against a latency-programmable multiplier model
module tb_booth_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  booth_op_sequencer_if bus();
  booth_op_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0, checks = 0;
  int mdl_lat = 0, mdl_cnt = 0, ia, ib;
  bit spur = 1'b0;
  // multiplier model: answers mdl_lat cycles after the start pulse (0 = never), spur injects a stray strobe
  initial begin
    bus.mul_valid_out = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(negedge clk);
      bus.mul_valid_out = spur;
      spur = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          ia = $signed(bus.mul_a);
          ib = $signed(bus.mul_b);
          bus.mul_product = ia * ib;
          bus.mul_valid_out = 1'b1;
        end
      end
      if (bus.mul_valid_in) mdl_cnt = mdl_lat;
    end
  end
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++;
    if ({bus.mul_a, bus.mul_b, bus.mul_valid_in, bus.out_valid, bus.out_product, bus.out_tag, bus.out_timeout, bus.busy, bus.fifo_count} !== '0)
      begin errors++; $display("FAIL reset_zero: outputs not all zero (out_valid=%b fifo_count=%0d busy=%b)", bus.out_valid, bus.fifo_count, bus.busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_single();
    int k, extra;
    bit stable;
    mdl_lat = 16;
    bus.out_ready = 1'b0;
    bus.in_a = 16'h0003; bus.in_b = 16'hFFFE; bus.in_tag = 4'd5; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mul_valid_in !== 1'b0 || bus.fifo_count !== 3'd1)
      begin errors++; $display("FAIL single_t1: mul_valid_in=%b fifo_count=%0d want 0/1", bus.mul_valid_in, bus.fifo_count); end
    @(negedge clk);
    checks++;
    if (bus.mul_valid_in !== 1'b1 || {bus.mul_a, bus.mul_b} !== 32'h0003_FFFE)
      begin errors++; $display("FAIL single_issue: mul_valid_in=%b a=%h b=%h want 1/0003/fffe", bus.mul_valid_in, bus.mul_a, bus.mul_b); end
    k = 0; extra = 0; stable = 1'b1;
    while (!bus.out_valid && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.mul_valid_in) extra++;
      if ({bus.mul_a, bus.mul_b} !== 32'h0003_FFFE) stable = 1'b0;
    end
    checks++;
    if (k !== 17) begin errors++; $display("FAIL single_latency: got %0d cycles want 17", k); end
    checks++;
    if (extra !== 0 || !stable) begin errors++; $display("FAIL single_hold: extra_pulses=%0d stable=%b want 0/1", extra, stable); end
    checks++;
    if ({bus.out_timeout, bus.out_tag, bus.out_product} !== {1'b0, 4'd5, 32'hFFFF_FFFA})
      begin errors++; $display("FAIL single_result: to=%b tag=%0d prod=%h want 0/5/fffffffa", bus.out_timeout, bus.out_tag, bus.out_product); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL single_consume: out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
  endtask
  task automatic test_fifo_full();
    int acc, k, got, pulses;
    logic [3:0] tags [4];
    logic [31:0] prods [4];
    mdl_lat = 4;
    bus.out_ready = 1'b0;
    bus.in_a = 16'd1; bus.in_b = 16'd2; bus.in_tag = 4'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_product !== 32'd2)
      begin errors++; $display("FAIL full_first: out_valid=%b prod=%h want 1/2", bus.out_valid, bus.out_product); end
    acc = 0; pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_a = 16'(i); bus.in_b = 16'd3; bus.in_tag = 4'(i); bus.in_valid = 1'b1;
      if (bus.in_ready) acc++;
      @(negedge clk);
      if (bus.mul_valid_in) pulses++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL full_accepted: got %0d want 4", acc); end
    checks++;
    if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL full_state: fifo_count=%0d in_ready=%b want 4/0", bus.fifo_count, bus.in_ready); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL full_no_issue: got %0d pulses want 0", pulses); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    got = 0; k = 0;
    while (got < 4 && k < 200) begin
      if (bus.out_valid) begin tags[got] = bus.out_tag; prods[got] = bus.out_product; got++; end
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL full_count: got %0d results want 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tags[i], prods[i]} !== {4'(i + 1), 32'(3 * (i + 1))})
        begin errors++; $display("FAIL full_order[%0d]: tag=%0d prod=%h want %0d/%h", i, tags[i], prods[i], i + 1, 3 * (i + 1)); end
    end
  endtask
  task automatic test_backpressure();
    int k, pulses;
    bit stable;
    mdl_lat = 4;
    bus.out_ready = 1'b0;
    bus.in_a = 16'h0010; bus.in_b = 16'h0010; bus.in_tag = 4'd6; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_tag = 4'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
    checks++;
    if ({bus.out_valid, bus.out_tag, bus.out_product} !== {1'b1, 4'd6, 32'h100})
      begin errors++; $display("FAIL bp_first: valid=%b tag=%0d prod=%h want 1/6/100", bus.out_valid, bus.out_tag, bus.out_product); end
    pulses = 0; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.mul_valid_in) pulses++;
      if ({bus.out_valid, bus.out_tag, bus.out_product} !== {1'b1, 4'd6, 32'h100}) stable = 1'b0;
    end
    checks++;
    if (pulses !== 0 || !stable || bus.fifo_count !== 3'd1)
      begin errors++; $display("FAIL bp_hold: pulses=%0d stable=%b fifo_count=%0d want 0/1/1", pulses, stable, bus.fifo_count); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.mul_valid_in !== 1'b1) begin errors++; $display("FAIL bp_release_issue: mul_valid_in=%b want 1", bus.mul_valid_in); end
    k = 0;
    while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
    checks++;
    if ({bus.out_valid, bus.out_timeout, bus.out_tag, bus.out_product} !== {1'b1, 1'b0, 4'd7, 32'd1})
      begin errors++; $display("FAIL bp_second: valid=%b to=%b tag=%0d prod=%h want 1/0/7/1", bus.out_valid, bus.out_timeout, bus.out_tag, bus.out_product); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic test_timeout();
    int k;
    mdl_lat = 0;
    bus.in_a = 16'd5; bus.in_b = 16'd5; bus.in_tag = 4'd8; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.mul_valid_in && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!bus.out_valid && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (k !== 24) begin errors++; $display("FAIL to_latency: got %0d cycles want 24", k); end
    checks++;
    if ({bus.out_timeout, bus.out_tag, bus.out_product} !== {1'b1, 4'd8, 32'd0})
      begin errors++; $display("FAIL to_result: to=%b tag=%0d prod=%h want 1/8/0", bus.out_timeout, bus.out_tag, bus.out_product); end
    mdl_lat = 4;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_a = 16'd2; bus.in_b = 16'd3; bus.in_tag = 4'd9; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
    checks++;
    if ({bus.out_valid, bus.out_timeout, bus.out_tag, bus.out_product} !== {1'b1, 1'b0, 4'd9, 32'd6})
      begin errors++; $display("FAIL to_next: valid=%b to=%b tag=%0d prod=%h want 1/0/9/6", bus.out_valid, bus.out_timeout, bus.out_tag, bus.out_product); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic test_coincide();
    int k;
    bit seen;
    mdl_lat = 23;
    bus.in_a = 16'h7FFF; bus.in_b = 16'h0002; bus.in_tag = 4'd10; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.mul_valid_in && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!bus.out_valid && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (k !== 24) begin errors++; $display("FAIL tie_latency: got %0d cycles want 24", k); end
    checks++;
    if ({bus.out_timeout, bus.out_tag, bus.out_product} !== {1'b0, 4'd10, 32'h0000_FFFE})
      begin errors++; $display("FAIL tie_result: to=%b tag=%0d prod=%h want 0/10/0000fffe", bus.out_timeout, bus.out_tag, bus.out_product); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    spur = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || bus.busy !== 1'b0) begin errors++; $display("FAIL spurious: result_seen=%b busy=%b want 0/0", seen, bus.busy); end
  endtask
  task automatic test_reset_mid();
    bit seen_res, seen_issue;
    mdl_lat = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_a = 16'(i + 1); bus.in_b = 16'd7; bus.in_tag = 4'(11 + i); bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL mid_queued: fifo_count=%0d busy=%b want 3/1", bus.fifo_count, bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mul_a, bus.mul_b, bus.mul_valid_in, bus.out_valid, bus.out_product, bus.out_tag, bus.out_timeout, bus.busy, bus.fifo_count} !== '0)
      begin errors++; $display("FAIL mid_reset_zero: out_valid=%b fifo_count=%0d busy=%b mul_a=%h", bus.out_valid, bus.fifo_count, bus.busy, bus.mul_a); end
    reset = 1'b0;
    seen_res = 1'b0; seen_issue = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen_res = 1'b1;
      if (bus.mul_valid_in) seen_issue = 1'b1;
    end
    checks++;
    if (seen_res || seen_issue)
      begin errors++; $display("FAIL mid_no_result: result_seen=%b issue_seen=%b want 0/0", seen_res, seen_issue); end
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fifo_full();
    test_backpressure();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_op_sequencer.md
# booth_op_sequencer

Operand sequencer that sits directly upstream of the Booth multiplier datapath. It buffers multiply requests from a valid/ready source in a small FIFO and issues them one at a time to the multiplier. For each request it holds the operands stable, pulses the multiplier's start, and waits for its done strobe. It then returns the 32-bit product with the request's tag on a valid/ready result port, and flags a timeout if the multiplier never answers.

## Interface
- WIDTH_IN, 16, operand width (multiplicand/multiplier)
- WIDTH_FP, 32, product width
- TAG_W, 4, request tag width
- DEPTH, 4, operand FIFO entries (power of two, ≥2)
- TIMEOUT, 24, max cycles in WAIT before abort (must exceed multiplier latency)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  WIDTH_IN  multiplicand
- in_b  in  WIDTH_IN  multiplier
- in_tag  in  TAG_W  request tag
- mul_a  out  WIDTH_IN  to multiplier multiplicand input
- mul_b  out  WIDTH_IN  to multiplier multiplier input
- mul_valid_in  out  1  one-cycle start pulse to multiplier
- mul_valid_out  in  1  multiplier done strobe
- mul_product  in  WIDTH_FP  multiplier product, sampled on mul_valid_out
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_product  out  WIDTH_FP  result product
- out_tag  out  TAG_W  tag of the request
- out_timeout  out  1  result aborted by timeout (out_product = 0)
- busy  out  1  state != IDLE or FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO push on in_valid && in_ready; in_ready = (fifo_count < DEPTH) && !reset. No push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- States:
  - IDLE → ISSUE when the FIFO is non-empty and the result slot is free (!out_valid || out_ready).
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE on mul_valid_out, or when wait_cnt == TIMEOUT-1.
- Entering ISSUE (registered):
  - mul_a/mul_b/cur_tag load from the FIFO head.
  - FIFO pops.
  - mul_valid_in = 1 for the ISSUE cycle only.
- mul_a/mul_b hold their value through WAIT and until the next issue.
- WAIT:
  - wait_cnt clears on ISSUE and increments each WAIT cycle.
  - On mul_valid_out: out_product ← mul_product, out_tag ← cur_tag, out_timeout ← 0, out_valid ← 1.
  - On timeout without mul_valid_out: out_product ← 0, out_tag ← cur_tag, out_timeout ← 1, out_valid ← 1.
  - mul_valid_out and timeout in the same cycle: the product wins (out_timeout = 0).
- mul_valid_out outside WAIT (IDLE or ISSUE) is ignored.
- out_valid clears on out_ready, unless a new result loads in the same cycle. A load cannot collide with an unconsumed result because of the issue condition.
- Products pass through unmodified (signed two's complement); no arithmetic in this block.
- Requests complete in strict FIFO order; one operation is in flight at most.

## Timing
- Reset value 0 for: mul_a, mul_b, mul_valid_in, out_valid, out_product, out_tag, out_timeout, busy, fifo_count. State = IDLE; FIFO empty.
- Reset mid-operation discards the FIFO contents, the in-flight request, and any pending result. No result is produced.
- Request pushed at cycle t into an idle, empty block:
  - ISSUE at t+2 (mul_valid_in high).
  - WAIT from t+3.
  - out_valid rises the cycle after mul_valid_out is sampled.
- Back-to-back: with out_ready held high, the next ISSUE occurs 1 cycle after the WAIT→IDLE return.
- Timeout result: out_valid rises the cycle after wait_cnt == TIMEOUT-1, i.e. TIMEOUT cycles after ISSUE.

## Structure
- Shared package booth_pkg: WIDTH_IN/WIDTH_FP defaults and the seq_state_e enum (IDLE, ISSUE, WAIT).
- Sub-module operand_fifo: DEPTH-entry synchronous FIFO of {tag, a, b} with count output.
- The FSM, timeout counter, and result register live in booth_op_sequencer.

## Test plan
- Single request a=0x0003, b=0xFFFE, tag=5; model answers 16 cycles after mul_valid_in with 0xFFFFFFFA. Expect one mul_valid_in pulse at t+2, mul_a/mul_b stable throughout WAIT, then out_valid with product 0xFFFFFFFA, tag 5, timeout 0.
- Push 5 requests back-to-back with the multiplier model stalled. Expect in_ready low after 4 accepted (fifo_count=4). After completions, results emerge with tags in push order.
- Hold out_ready low with a result pending and FIFO non-empty. Expect no mul_valid_in until out_ready=1; out_product/out_tag remain stable.
- Multiplier model never answers. Expect out_valid with out_timeout=1, product 0, TIMEOUT cycles after ISSUE; the next request then issues normally.
- mul_valid_out coincides with wait_cnt == TIMEOUT-1. Expect the real product with out_timeout=0. A spurious mul_valid_out in IDLE produces no result.
- Assert reset during WAIT with 3 requests queued. Expect all outputs 0 and fifo_count 0 the next cycle, and no result from the aborted request.
